// File: rtl/onehot_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : onehot_rr_arbiter
// Purpose  : Round-robin arbiter for NUM_REQ requesters. The winner is
//            presented as a binary index and as a registered one-hot
//            grant vector. The owner keeps the grant while it requests.
//            An optional hold limit forces rotation when others wait.
// Revision : 1.0 - initial release
// ============================================================================
module onehot_rr_arbiter #(
    parameter int NUM_REQ   = 16,
    parameter int IDX_WIDTH = 4,
    parameter int MAX_HOLD  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    output logic                 grant_valid,
    output logic [IDX_WIDTH-1:0] grant_idx,
    output logic [NUM_REQ-1:0]   grant_onehot,
    output logic                 preempt
);

    // Hold counter only needs to reach MAX_HOLD-1; keep at least one bit.
    localparam int                   c_HOLD_W      = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam int                   c_HOLD_LAST_I = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
    localparam logic [c_HOLD_W-1:0]  c_HOLD_LAST   = c_HOLD_W'(c_HOLD_LAST_I);
    localparam logic [IDX_WIDTH-1:0] c_LAST_IDX    = IDX_WIDTH'(NUM_REQ - 1);

    // Registered state
    logic                 r_valid;
    logic [IDX_WIDTH-1:0] r_idx;
    logic [NUM_REQ-1:0]   r_onehot;
    logic                 r_preempt;
    logic [IDX_WIDTH-1:0] r_ptr;
    logic [c_HOLD_W-1:0]  r_hold;

    // Next-state values
    logic                 w_valid;
    logic [IDX_WIDTH-1:0] w_idx;
    logic [NUM_REQ-1:0]   w_onehot;
    logic                 w_preempt;
    logic [IDX_WIDTH-1:0] w_ptr;
    logic [c_HOLD_W-1:0]  w_hold;

    // Search helpers
    logic [IDX_WIDTH-1:0] w_succ_ptr;
    logic [NUM_REQ-1:0]   w_others;
    logic [IDX_WIDTH:0]   w_idle_hit;
    logic [IDX_WIDTH:0]   w_rot_hit;
    logic                 w_owner_req;
    logic                 w_at_limit;

    // Returns {found, index} of the first set bit of r scanning from p
    // upwards and wrapping at NUM_REQ (not at 2**IDX_WIDTH).
    function automatic logic [IDX_WIDTH:0] f_search(
        input logic [NUM_REQ-1:0]   r,
        input logic [IDX_WIDTH-1:0] p
    );
        logic                 found;
        logic [IDX_WIDTH-1:0] idx;
        int                   k;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = int'(p) + i;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            if (!found && r[k]) begin
                found = 1'b1;
                idx   = k[IDX_WIDTH-1:0];
            end
        end
        return {found, idx};
    endfunction

    // Candidate winners: fresh search from the pointer when idle, and a
    // search past the current owner (owner masked) for release/preempt.
    always_comb begin
        w_succ_ptr  = (r_idx == c_LAST_IDX) ? '0 : r_idx + 1'b1;
        w_others    = req & ~r_onehot;
        w_owner_req = req[r_idx];
        w_at_limit  = (MAX_HOLD != 0) && (r_hold == c_HOLD_LAST);
        w_idle_hit  = f_search(req, r_ptr);
        w_rot_hit   = f_search(w_others, w_succ_ptr);
    end

    // Grant state transitions: idle, hold, preempt, release/handover.
    always_comb begin
        w_valid   = r_valid;
        w_idx     = r_idx;
        w_ptr     = r_ptr;
        w_hold    = r_hold;
        w_preempt = 1'b0;
        if (!r_valid) begin
            if (w_idle_hit[IDX_WIDTH]) begin
                w_valid = 1'b1;
                w_idx   = w_idle_hit[IDX_WIDTH-1:0];
                w_hold  = '0;
            end
        end else if (w_owner_req) begin
            if (!w_at_limit) begin
                w_hold = r_hold + 1'b1;
            end else if (|w_others) begin
                w_ptr     = w_succ_ptr;
                w_idx     = w_rot_hit[IDX_WIDTH-1:0];
                w_hold    = '0;
                w_preempt = 1'b1;
            end
            // At the limit with nobody waiting: hold count saturates.
        end else begin
            // Owner released (takes precedence over a coincident limit hit).
            w_ptr  = w_succ_ptr;
            w_hold = '0;
            if (w_rot_hit[IDX_WIDTH]) begin
                w_idx = w_rot_hit[IDX_WIDTH-1:0];
            end else begin
                w_valid = 1'b0;
            end
        end
        w_onehot = w_valid ? (NUM_REQ'(1) << w_idx) : '0;
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_idx     <= '0;
            r_onehot  <= '0;
            r_preempt <= 1'b0;
            r_ptr     <= '0;
            r_hold    <= '0;
        end else begin
            r_valid   <= w_valid;
            r_idx     <= w_idx;
            r_onehot  <= w_onehot;
            r_preempt <= w_preempt;
            r_ptr     <= w_ptr;
            r_hold    <= w_hold;
        end
    end

    assign grant_valid  = r_valid;
    assign grant_idx    = r_idx;
    assign grant_onehot = r_onehot;
    assign preempt      = r_preempt;

endmodule
`default_nettype wire

// File: tb/tb_onehot_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_onehot_rr_arbiter
// Purpose  : Directed self-checking bench for onehot_rr_arbiter, covering a
//            16-requester instance and a 5-requester (non power of 2) one.
// Revision : 1.0 - initial release
// ============================================================================
module tb_onehot_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req_a;
    logic [4:0]  req_b;

    logic        gv_a;
    logic [3:0]  gi_a;
    logic [15:0] oh_a;
    logic        pe_a;

    logic        gv_b;
    logic [2:0]  gi_b;
    logic [4:0]  oh_b;
    logic        pe_b;

    int total  = 0;
    int passed = 0;

    onehot_rr_arbiter #(.NUM_REQ(16), .IDX_WIDTH(4), .MAX_HOLD(8)) u_dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req_a),
        .grant_valid  (gv_a),
        .grant_idx    (gi_a),
        .grant_onehot (oh_a),
        .preempt      (pe_a)
    );

    onehot_rr_arbiter #(.NUM_REQ(5), .IDX_WIDTH(3), .MAX_HOLD(8)) u_dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req_b),
        .grant_valid  (gv_b),
        .grant_idx    (gi_b),
        .grant_onehot (oh_b),
        .preempt      (pe_b)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_a(input string tag, input bit v, input int idx, input bit pe);
        logic [15:0] exp_oh;
        exp_oh = v ? (16'h0001 << idx) : 16'h0000;
        chk({tag, ".valid"},   32'(gv_a), 32'(v));
        chk({tag, ".idx"},     32'(gi_a), 32'(idx));
        chk({tag, ".onehot"},  32'(oh_a), 32'(exp_oh));
        chk({tag, ".preempt"}, 32'(pe_a), 32'(pe));
    endtask

    task automatic chk_b(input string tag, input bit v, input int idx, input bit pe);
        logic [4:0] exp_oh;
        exp_oh = v ? (5'b00001 << idx) : 5'b00000;
        chk({tag, ".valid"},   32'(gv_b), 32'(v));
        chk({tag, ".idx"},     32'(gi_b), 32'(idx));
        chk({tag, ".onehot"},  32'(oh_b), 32'(exp_oh));
        chk({tag, ".preempt"}, 32'(pe_b), 32'(pe));
    endtask

    initial begin
        int owners [5];
        owners = '{0, 5, 10, 15, 0};

        // Reset held 3 cycles with every request high.
        rst_n = 1'b0;
        req_a = 16'hFFFF;
        req_b = 5'b00000;
        step(); step(); step();
        chk_a("reset", 1'b0, 0, 1'b0);
        chk_b("reset_b", 1'b0, 0, 1'b0);
        rst_n = 1'b1;
        step();
        chk_a("first_grant", 1'b1, 0, 1'b0);

        // Round-robin order 0,5,10,15,0 with seamless handovers.
        rst_n = 1'b0;
        req_a = 16'h0000;
        step();
        chk_a("rr_reset", 1'b0, 0, 1'b0);
        rst_n = 1'b1;
        req_a = 16'h8421;
        step();
        chk_a("rr_g0", 1'b1, 0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            req_a = 16'h8421;
            step();
            chk_a($sformatf("rr_hold%0d", k), 1'b1, owners[k], 1'b0);
            req_a = 16'h8421 & ~(16'h0001 << owners[k]);
            step();
            chk_a($sformatf("rr_hand%0d", k), 1'b1, owners[k+1], 1'b0);
        end

        // Preemption between requesters 3 and 7.
        rst_n = 1'b0;
        req_a = 16'h0000;
        step();
        rst_n = 1'b1;
        req_a = 16'h0088;
        step();
        chk_a("pre_3_c1", 1'b1, 3, 1'b0);
        for (int c = 2; c <= 8; c++) begin
            step();
            chk_a($sformatf("pre_3_c%0d", c), 1'b1, 3, 1'b0);
        end
        step();
        chk_a("pre_to7", 1'b1, 7, 1'b1);
        for (int c = 2; c <= 8; c++) begin
            step();
            chk_a($sformatf("pre_7_c%0d", c), 1'b1, 7, 1'b0);
        end
        step();
        chk_a("pre_to3", 1'b1, 3, 1'b1);

        // Lone requester 3 is never preempted.
        req_a = 16'h0008;
        for (int c = 1; c <= 24; c++) begin
            step();
            chk_a($sformatf("solo_c%0d", c), 1'b1, 3, 1'b0);
        end

        // Owner 2 releases exactly on its limit edge while 9 waits.
        rst_n = 1'b0;
        req_a = 16'h0000;
        step();
        rst_n = 1'b1;
        req_a = 16'h0204;
        step();
        chk_a("coll_c1", 1'b1, 2, 1'b0);
        for (int c = 2; c <= 8; c++) begin
            step();
            chk_a($sformatf("coll_c%0d", c), 1'b1, 2, 1'b0);
        end
        req_a = 16'h0200;
        step();
        chk_a("coll_to9", 1'b1, 9, 1'b0);

        // Move the pointer away from 0, then reset mid-grant while 6 owns.
        req_a = 16'h0040;
        step();
        chk_a("mid_g6", 1'b1, 6, 1'b0);
        step();
        chk_a("mid_g6b", 1'b1, 6, 1'b0);
        rst_n = 1'b0;
        req_a = 16'h0842;
        step();
        chk_a("mid_reset", 1'b0, 0, 1'b0);
        rst_n = 1'b1;
        step();
        chk_a("mid_restart", 1'b1, 1, 1'b0);

        // Five requesters: wrap from 4 to 0, and limit rotation across the wrap.
        req_b = 5'b10000;
        step();
        chk_b("b_g4", 1'b1, 4, 1'b0);
        req_b = 5'b00001;
        step();
        chk_b("b_wrap0", 1'b1, 0, 1'b0);
        req_b = 5'b10001;
        for (int c = 2; c <= 8; c++) begin
            step();
            chk_b($sformatf("b_0_c%0d", c), 1'b1, 0, 1'b0);
        end
        step();
        chk_b("b_pre4", 1'b1, 4, 1'b1);
        for (int c = 2; c <= 8; c++) begin
            step();
            chk_b($sformatf("b_4_c%0d", c), 1'b1, 4, 1'b0);
        end
        step();
        chk_b("b_pre0", 1'b1, 0, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/onehot_rr_arbiter.md
# onehot_rr_arbiter

- Round-robin arbiter that shares one resource among `NUM_REQ` requesters.
- Presents the winner both as a binary index and as a one-hot grant vector; the one-hot vector drives the per-requester select lines directly.
- Grants are held while the owner keeps requesting, with an optional hold limit that forces rotation.
- Sits in front of the one-hot channel-select path, replacing a free-running index source.

## Interface

Parameters:
- `NUM_REQ`, 16, number of requesters; 2..2**`IDX_WIDTH`.
- `IDX_WIDTH`, 4, width of the binary grant index.
- `MAX_HOLD`, 8, maximum consecutive grant cycles before forced rotation when others wait; 0 disables the limit.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req` in `NUM_REQ`: request per requester. Level-sensitive; held high for the whole time the resource is wanted.
- `grant_valid` out 1: a grant is active.
- `grant_idx` out `IDX_WIDTH`: binary index of the current owner.
- `grant_onehot` out `NUM_REQ`: `1 << grant_idx` when `grant_valid`, else all zero.
- `preempt` out 1: one-cycle pulse in the first cycle of a grant taken away by the hold limit.

## Operation

- **Registered state:** `grant_valid`, `grant_idx`, `grant_onehot`, `preempt`, rotation pointer `ptr` (`IDX_WIDTH` bits), hold counter `hold_cnt` (ceil(log2(`MAX_HOLD`+1)) bits, min 1).
- **Search rule:** winner = first index `i` with `req[i]`=1, scanning `ptr`, `ptr`+1, …, `NUM_REQ`-1, 0, …, `ptr`-1.
  - Wrap is at `NUM_REQ`, not 2**`IDX_WIDTH`.
- **State IDLE (`grant_valid`=0):**
  - No request: stay in IDLE.
  - Any request: go to GRANTED with `grant_idx`=winner, `ptr` unchanged, `hold_cnt`=0.
- **State GRANTED, owner still requesting (`req[grant_idx]`=1):**
  - Not at the hold limit (`MAX_HOLD`=0 or `hold_cnt` < `MAX_HOLD`-1): keep the grant; `hold_cnt` increments.
  - At the limit (`MAX_HOLD`>0 and `hold_cnt`=`MAX_HOLD`-1) with at least one other requester high: preempt.
    - `ptr`=(`grant_idx`+1) mod `NUM_REQ`.
    - New winner found with the owner's bit masked out.
    - `hold_cnt`=0, `preempt`=1 for that one cycle.
  - At the limit with no other requester: keep the grant; `hold_cnt` saturates at `MAX_HOLD`-1; no preempt.
- **State GRANTED, owner releases (`req[grant_idx]`=0):**
  - `ptr`=(`grant_idx`+1) mod `NUM_REQ`.
  - Search from the new `ptr` over the current `req`.
  - Winner found: hand over at the same edge, with no idle cycle; `hold_cnt`=0.
  - No winner: go to IDLE.
- **`grant_onehot`:** registered alongside `grant_idx`, never computed combinationally from outputs. Exactly one bit is set whenever `grant_valid`=1.

## Timing

- **Reset:** with `rst_n`=0 at a rising edge, next cycle `grant_valid`=0, `grant_idx`=0, `grant_onehot`=0, `preempt`=0, `ptr`=0, `hold_cnt`=0.
  - Applies mid-grant as well; the `req` sampled at that edge is ignored.
- **Grant latency:** 1 cycle. A request sampled at edge N gives `grant_valid`=1 after edge N.
- **Handover:**
  - Owner drops `req` before edge N: the new owner's grant is visible after edge N.
  - The old owner holds no grant after edge N.
- **Hold length:** with `MAX_HOLD`=M and contention, the owner holds exactly M cycles, then the grant moves.
- **Simultaneous events:**
  - Owner releasing on the same edge it would hit the limit: treat as a release; `preempt`=0.
  - Owner dropping and re-raising `req` within one cycle is invisible.
  - A requester that drops `req` before being granted is never granted.
- **Outputs:** all registered; no combinational path from `req`.

## Test plan

Defaults: `NUM_REQ`=16, `IDX_WIDTH`=4, `MAX_HOLD`=8.

- **Reset:** hold `rst_n`=0 for 3 cycles with `req`=16'hFFFF -> all outputs 0. Release reset -> next cycle `grant_idx`=0, `grant_onehot`=16'h0001.
- **Round-robin order:** `req`=16'h8421 held; each owner drops for 1 cycle after 2 cycles of grant -> grant order 0,5,10,15,0 with no IDLE gaps. `grant_onehot` tracks `1<<grant_idx` every cycle.
- **Wrap and non-power-of-2:** `NUM_REQ`=5, `IDX_WIDTH`=3; owner 4 releases with `req[0]` high -> grant goes to 0; `grant_idx` never reaches 5..7.
- **Preemption:** `req[3]` and `req[7]` held continuously -> 3 owns 8 cycles, then 7 for 8 cycles, then 3. `preempt` pulses once per switch. With only `req[3]` high, 3 holds 20 or more cycles with no preempt.
- **Release/limit collision:** owner 2 drops `req` on exactly the limit cycle while `req[9]`=1 -> grant moves to 9, `preempt`=0.
- **Reset mid-grant:** `rst_n` low for 1 cycle while 6 owns -> next cycle idle. After reset deasserts, search restarts from `ptr`=0.
